// File: rtl/ifetch_ctrl_pkg.sv
// Shared fetch-stage types: FSM state encoding, the decode-facing entry
// record and the architectural reset PC.
package ifetch_ctrl_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  localparam u64 PC_RESET = 64'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DROP  = 2'd2,
    VALID = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic valid;
    u64   pc;
    u32   instr;
    logic exc;
  } fetch_out_t;

endpackage

// File: rtl/ifetch_ctrl.sv
// Fetch-stage controller: one outstanding instruction request at a time,
// valid/ready hand-off to decode, and flush absorption mid-request.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_write,
  input  logic               flush,
  output logic               ireq_valid,
  output logic [ADDR_W-1:0]  ireq_addr,
  input  logic               iresp_data_ok,
  input  logic [INSTR_W-1:0] iresp_data,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_exc,
  input  logic               id_ready
);

  fetch_state_t       r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_exc;

  logic w_launch;
  logic w_misaligned;

  // A flush always wins over a launch; VALID launches only on a completed handshake.
  assign w_launch     = !flush && ((r_state == IDLE) || ((r_state == VALID) && id_ready));
  assign w_misaligned = (pc[1:0] != 2'b00);

  // Gated by reset so the PC register is never advanced while held in reset.
  assign pc_write = reset && (w_launch || flush);

  assign ireq_valid = (r_state == BUSY) || (r_state == DROP);
  assign ireq_addr  = ireq_valid ? r_pc : '0;

  assign if_valid = (r_state == VALID);
  assign if_pc    = if_valid ? r_pc    : '0;
  assign if_instr = if_valid ? r_instr : '0;
  assign if_exc   = if_valid && r_exc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_instr <= '0;
      r_exc   <= 1'b0;
    end else if (w_launch) begin
      r_pc <= pc;
      if (w_misaligned) begin
        r_state <= VALID;
        r_exc   <= 1'b1;
        r_instr <= '0;
      end else begin
        r_state <= BUSY;
        r_exc   <= 1'b0;
      end
    end else begin
      case (r_state)
        BUSY: begin
          if (iresp_data_ok) begin
            if (!flush) begin
              r_instr <= iresp_data;
              r_state <= VALID;
            end else begin
              r_state <= IDLE;
            end
          end else if (flush) begin
            r_state <= DROP;
          end
        end
        // The flushed request stays on the bus until its response drains.
        DROP: begin
          if (iresp_data_ok) begin
            r_state <= IDLE;
          end
        end
        VALID: begin
          if (flush) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: per-cycle vector table, a scoreboard of expected
// decode entries, and hand-written reset/flush/bus-delay sequences.
module tb_ifetch_ctrl;
  import ifetch_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic [63:0] pc;
  logic        pc_write;
  logic        flush;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_exc;
  logic        id_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] pc;
    logic        flush;
    logic        dok;
    logic [31:0] data;
    logic        idr;
    logic        ePcw;
    logic        eRv;
    logic [63:0] eRa;
    fetch_out_t  eIf;
    logic        push;
    fetch_out_t  pEnt;
  } vec_t;

  vec_t       vecs[$];
  fetch_out_t sb[$];

  ifetch_ctrl #(.ADDR_W(64), .INSTR_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .pc_write      (pc_write),
    .flush         (flush),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_exc        (if_exc),
    .id_ready      (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkv(input logic [63:0] p, input logic fl, input logic dok,
                               input logic [31:0] d, input logic idr, input logic pcw,
                               input logic rv, input logic [63:0] ra, input logic fv,
                               input logic [63:0] fpc, input logic [31:0] fins,
                               input logic fexc, input logic psh, input logic [31:0] pins,
                               input logic pexc);
    vec_t v;
    v.pc   = p;    v.flush = fl;  v.dok = dok; v.data = d; v.idr = idr;
    v.ePcw = pcw;  v.eRv   = rv;  v.eRa = ra;
    v.eIf  = '{valid: fv, pc: fpc, instr: fins, exc: fexc};
    v.push = psh;
    v.pEnt = '{valid: 1'b1, pc: p, instr: pins, exc: pexc};
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_pc_write"},   pc_write,   0);
    checkOutput({tag, "_ireq_valid"}, ireq_valid, 0);
    checkOutput({tag, "_ireq_addr"},  ireq_addr,  0);
    checkOutput({tag, "_if_valid"},   if_valid,   0);
    checkOutput({tag, "_if_pc"},      if_pc,      0);
    checkOutput({tag, "_if_instr"},   if_instr,   0);
    checkOutput({tag, "_if_exc"},     if_exc,     0);
  endtask

  // Drives one cycle of inputs, then monitors the protocol and the decode hand-off.
  task automatic drive(input logic [63:0] p, input logic fl, input logic dok,
                       input logic [31:0] d, input logic idr);
    fetch_out_t e;
    @(negedge clk);
    reset = 1'b1; pc = p; flush = fl; iresp_data_ok = dok; iresp_data = d; id_ready = idr;
    #1;
    if (iresp_data_ok && !ireq_valid) begin
      checks++; errors++;
      $display("[TB] FAIL bus_protocol actual=data_ok_without_request required=none");
    end
    checkOutput("no_stale_beef", if_valid && (if_instr == 32'hDEAD_BEEF), 0);
    if (if_valid && id_ready && !flush) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL sb_unexpected actual=pc_%h required=no_entry", if_pc);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_pc",    if_pc,    e.pc);
        checkOutput("sb_instr", if_instr, e.instr);
        checkOutput("sb_exc",   if_exc,   e.exc);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string n;
    drive(v.pc, v.flush, v.dok, v.data, v.idr);
    n = $sformatf("v%0d", idx);
    checkOutput({n, "_pc_write"},   pc_write,   v.ePcw);
    checkOutput({n, "_ireq_valid"}, ireq_valid, v.eRv);
    checkOutput({n, "_ireq_addr"},  ireq_addr,  v.eRa);
    checkOutput({n, "_if_valid"},   if_valid,   v.eIf.valid);
    checkOutput({n, "_if_pc"},      if_pc,      v.eIf.pc);
    checkOutput({n, "_if_instr"},   if_instr,   v.eIf.instr);
    checkOutput({n, "_if_exc"},     if_exc,     v.eIf.exc);
    if (v.push) sb.push_back(v.pEnt);
  endtask

  initial begin
    int seen;
    logic got;

    // Cycle-by-cycle trace: aligned fetches, a 5-cycle decode stall, flush in
    // BUSY with a late response, flush coinciding with data_ok, misaligned PC.
    vecs.push_back(mkv(64'h8000_0000,0,0,0,1,            1,0,0,             0,0,0,0,                      1,32'h13,0));
    vecs.push_back(mkv(64'h8000_0004,0,1,32'h13,1,       0,1,64'h8000_0000, 0,0,0,0,                      0,0,0));
    vecs.push_back(mkv(64'h8000_0004,0,0,0,1,            1,0,0,             1,64'h8000_0000,32'h13,0,     1,32'h93,0));
    vecs.push_back(mkv(64'h8000_0008,0,1,32'h93,1,       0,1,64'h8000_0004, 0,0,0,0,                      0,0,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mkv(64'h8000_0008,0,0,0,0,          0,0,0,             1,64'h8000_0004,32'h93,0,     0,0,0));
    vecs.push_back(mkv(64'h8000_0008,0,0,0,1,            1,0,0,             1,64'h8000_0004,32'h93,0,     1,32'h1111_1111,0));
    vecs.push_back(mkv(64'h8000_000C,0,0,0,1,            0,1,64'h8000_0008, 0,0,0,0,                      0,0,0));
    vecs.push_back(mkv(64'h8000_000C,0,1,32'h1111_1111,1,0,1,64'h8000_0008, 0,0,0,0,                      0,0,0));
    vecs.push_back(mkv(64'h8000_000C,0,0,0,1,            1,0,0,             1,64'h8000_0008,32'h1111_1111,0, 0,0,0));
    vecs.push_back(mkv(64'h8000_0010,1,0,0,1,            1,1,64'h8000_000C, 0,0,0,0,                      0,0,0));
    vecs.push_back(mkv(64'h9000_0000,0,0,0,1,            0,1,64'h8000_000C, 0,0,0,0,                      0,0,0));
    vecs.push_back(mkv(64'h9000_0000,0,0,0,1,            0,1,64'h8000_000C, 0,0,0,0,                      0,0,0));
    vecs.push_back(mkv(64'h9000_0000,0,1,32'hDEAD_BEEF,1,0,1,64'h8000_000C, 0,0,0,0,                      0,0,0));
    vecs.push_back(mkv(64'h9000_0000,0,0,0,1,            1,0,0,             0,0,0,0,                      1,32'h2222_2222,0));
    vecs.push_back(mkv(64'h9000_0004,0,1,32'h2222_2222,1,0,1,64'h9000_0000, 0,0,0,0,                      0,0,0));
    vecs.push_back(mkv(64'h9000_0004,0,0,0,1,            1,0,0,             1,64'h9000_0000,32'h2222_2222,0, 0,0,0));
    vecs.push_back(mkv(64'h9000_0008,1,1,32'h3333_3333,1,1,1,64'h9000_0004, 0,0,0,0,                      0,0,0));
    vecs.push_back(mkv(64'h8000_0002,0,0,0,1,            1,0,0,             0,0,0,0,                      1,32'h0,1));
    vecs.push_back(mkv(64'h8000_0006,0,0,0,0,            0,0,0,             1,64'h8000_0002,32'h0,1,      0,0,0));
    vecs.push_back(mkv(64'h8000_0100,0,0,0,1,            1,0,0,             1,64'h8000_0002,32'h0,1,      1,32'h4444_4444,0));
    vecs.push_back(mkv(64'h8000_0104,0,0,0,1,            0,1,64'h8000_0100, 0,0,0,0,                      0,0,0));

    reset = 1'b0; pc = PC_RESET; flush = 1'b0;
    iresp_data_ok = 1'b0; iresp_data = '0; id_ready = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      checkAllZero("reset");
    end

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Asynchronous reset in the middle of an outstanding request.
    @(negedge clk);
    #2 reset = 1'b0;
    #1 checkAllZero("async_reset");
    sb.delete();
    @(negedge clk); #1;
    checkAllZero("reset_hold");

    // Release with a flush: IDLE holds but still lets the PC load.
    drive(64'h8000_0000, 1, 0, 0, 1);
    checkOutput("idle_flush_pc_write", pc_write,   1);
    checkOutput("idle_flush_no_req",   ireq_valid, 0);

    drive(64'h8000_0040, 0, 0, 0, 1);
    checkOutput("restart_pc_write", pc_write, 1);
    sb.push_back('{valid: 1'b1, pc: 64'h8000_0040, instr: 32'h5555_5555, exc: 1'b0});

    // Bus answers on the third request cycle; bounded wait for the entry.
    seen = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      drive(64'h8000_0044, 0, 0, 0, 1);
      if (if_valid) begin
        got = 1'b1;
      end else if (ireq_valid) begin
        seen++;
        checkOutput("slow_bus_addr_hold", ireq_addr, 64'h8000_0040);
        checkOutput("slow_bus_no_pc_write", pc_write, 0);
        if (seen == 3) begin
          iresp_data_ok = 1'b1;
          iresp_data    = 32'h5555_5555;
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL slow_bus_timeout actual=no_if_valid required=if_valid");
    end

    // Flush while BUSY for 8000_0044, response drains in DROP.
    drive(64'h8000_0048, 1, 0, 0, 1);
    checkOutput("busy_flush_pc_write", pc_write, 1);
    drive(64'h9000_0000, 0, 1, 32'hDEAD_BEEF, 1);
    checkOutput("drop_req_valid", ireq_valid, 1);
    checkOutput("drop_req_addr",  ireq_addr,  64'h8000_0044);
    drive(64'h9000_0000, 0, 0, 0, 1);
    checkOutput("after_drop_launch", pc_write, 1);
    drive(64'h9000_0004, 0, 1, 32'h6666_6666, 1);

    // Flush while VALID drops the entry without a hand-off.
    drive(64'h9000_0004, 1, 0, 0, 1);
    checkOutput("valid_flush_if_valid", if_valid, 1);
    checkOutput("valid_flush_instr",    if_instr, 32'h6666_6666);
    checkOutput("valid_flush_pc_write", pc_write, 1);
    drive(64'h9000_0004, 1, 0, 0, 1);
    checkOutput("dropped_if_valid", if_valid,   0);
    checkOutput("dropped_no_req",   ireq_valid, 0);

    checkOutput("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
